// File: rtl/seg_pkg.sv
// seg_pkg: glyph table, blank/dash glyphs, mode encoding and
// a BCD width helper shared by the seven-segment scan controller.
package seg_pkg;

  localparam logic MODE_HEX = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // Active-low cathodes, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    CV_IDLE,
    CV_RUN
  } cv_state_e;

  // Decimal digits needed to hold any w-bit unsigned value.
  function automatic int bcd_digits(input int w);
    longint unsigned lim;
    longint unsigned p;
    int n;
    lim = (64'd1 << w) - 64'd1;
    n = 1;
    p = 64'd10;
    for (int i = 0; i < 12; i++) begin
      if (p <= lim) begin
        n = n + 1;
        p = p * 64'd10;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/seg_bin2bcd.sv
// seg_bin2bcd: sequential shift-add-3 binary to BCD converter.
// Ports: clk, rst (sync, high), start, bin in; busy, bcd, ovf out.
module seg_bin2bcd
  import seg_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int DATA_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   bin,
  output logic                busy,
  output logic [4*DIGITS-1:0] bcd,
  output logic                ovf
);

  localparam int NB = bcd_digits(DATA_W);
  localparam int NW = (NB > DIGITS) ? NB : DIGITS;
  localparam int BW = 4 * NW;
  localparam int CW = $clog2(DATA_W + 1);

  cv_state_e state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [BW-1:0]     acc_q, acc_d;
  logic [BW-1:0]     adj;
  logic [BW-1:0]     nxt;
  logic [BW+DATA_W-1:0] cat;

  // One conversion step: add 3 to every digit >= 5, then shift
  // the next binary bit into the BCD accumulator.
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < NW; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    cat = {adj, sr_q} << 1;
    nxt = cat[BW+DATA_W-1:DATA_W];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    unique case (state_q)
      CV_IDLE: begin
        if (start) begin
          state_d = CV_RUN;
          cnt_d   = CW'(DATA_W);
          sr_d    = bin;
          acc_d   = '0;
        end
      end
      CV_RUN: begin
        acc_d = nxt;
        sr_d  = cat[DATA_W-1:0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = CV_IDLE;
        end
      end
      default: state_d = CV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CV_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
    end
  end

  assign busy = (state_q == CV_RUN);

  // bcd/ovf show the result of the step in flight, so they are
  // the final answer during the last busy cycle.
  assign bcd = nxt[4*DIGITS-1:0];

  if (NW > DIGITS) begin : g_ovf
    assign ovf = |nxt[BW-1:4*DIGITS];
  end else begin : g_no_ovf
    assign ovf = 1'b0;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: hex/decimal value to multiplexed 7-seg display.
// In: clk, rst, load, data, mode, dots_in. Out: busy, seg, dp, an.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int DATA_W   = 24,
  parameter int DIV      = 100000,
  parameter int BLANK_LZ = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              mode,
  input  logic [DIGITS-1:0] dots_in,
  output logic              busy,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] an
);

  localparam int HW = 4 * DIGITS;
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = $clog2(DIV);
  localparam int CW = $clog2(DATA_W + 1);

  logic              cv_busy;
  logic              cv_ovf;
  logic [HW-1:0]     cv_bcd;
  logic              acc_hex;
  logic              acc_dec;
  logic              cv_done;
  logic [HW+DATA_W-1:0] hex_ext;
  logic [HW-1:0]     hex_val;
  logic              unused_hi;

  logic [HW-1:0]     digits_q, digits_d;
  logic [DIGITS-1:0] dots_q, dots_d;
  logic [DIGITS-1:0] pdots_q, pdots_d;
  logic              ovf_q, ovf_d;
  logic [CW-1:0]     left_q, left_d;
  logic [DW-1:0]     div_q, div_d;
  logic [SW-1:0]     scan_q, scan_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] an_q, an_d;

  logic              tick;
  logic [DIGITS-1:0] lz;
  logic [3:0]        nib;
  logic              dot;
  logic              blank;

  assign acc_hex = load && !cv_busy && (mode == MODE_HEX);
  assign acc_dec = load && !cv_busy && (mode == MODE_DEC);

  // Zero-extend short values, drop nibbles above the display.
  assign hex_ext   = {{HW{1'b0}}, data};
  assign hex_val   = hex_ext[HW-1:0];
  assign unused_hi = ^hex_ext[HW+DATA_W-1:HW];

  seg_bin2bcd #(
    .DIGITS (DIGITS),
    .DATA_W (DATA_W)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (acc_dec),
    .bin   (data),
    .busy  (cv_busy),
    .bcd   (cv_bcd),
    .ovf   (cv_ovf)
  );

  assign busy = cv_busy;

  // left_q tracks the converter so the digit registers swap
  // on the same edge that busy falls.
  assign cv_done = (left_q == CW'(1));

  always_comb begin
    digits_d = digits_q;
    dots_d   = dots_q;
    pdots_d  = pdots_q;
    ovf_d    = ovf_q;
    left_d   = left_q;
    if (acc_hex) begin
      digits_d = hex_val;
      dots_d   = dots_in;
      ovf_d    = 1'b0;
    end
    if (acc_dec) begin
      pdots_d = dots_in;
      left_d  = CW'(DATA_W);
    end else if (left_q != '0) begin
      left_d = left_q - 1'b1;
    end
    if (cv_done) begin
      digits_d = cv_bcd;
      dots_d   = pdots_q;
      ovf_d    = cv_ovf;
    end
  end

  assign tick = (div_q == DW'(DIV - 1));

  always_comb begin
    div_d  = tick ? '0 : div_q + 1'b1;
    scan_d = scan_q;
    if (tick) begin
      if (scan_q == SW'(DIGITS - 1)) begin
        scan_d = '0;
      end else begin
        scan_d = scan_q + 1'b1;
      end
    end
  end

  // lz[i]: digits i..DIGITS-1 are all zero.
  always_comb begin
    lz = '0;
    lz[DIGITS-1] = (digits_q[HW-1 -: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      lz[i] = lz[i+1] && (digits_q[4*i +: 4] == 4'd0);
    end
  end

  always_comb begin
    nib   = '0;
    dot   = 1'b0;
    blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_q == SW'(i)) begin
        nib   = digits_q[4*i +: 4];
        dot   = dots_q[i];
        blank = lz[i] && (i != 0);
      end
    end
    if (ovf_q) begin
      seg_d = SEG_DASH;
    end else if ((BLANK_LZ != 0) && blank) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = HEX_GLYPH[nib];
    end
    dp_d = ~dot;
    an_d = ~(DIGITS'(1) << scan_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q <= '0;
      dots_q   <= '0;
      pdots_q  <= '0;
      ovf_q    <= 1'b0;
      left_q   <= '0;
      div_q    <= '0;
      scan_q   <= '0;
      seg_q    <= SEG_BLANK;
      dp_q     <= 1'b1;
      an_q     <= '1;
    end else begin
      digits_q <= digits_d;
      dots_q   <= dots_d;
      pdots_q  <= pdots_d;
      ovf_q    <= ovf_d;
      left_q   <= left_d;
      div_q    <= div_d;
      scan_q   <= scan_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl (DIV=4),
// an 8x24 instance plus a 4x16 instance for decimal overflow.
module tb_seg_scan_ctrl;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        load;
  logic [23:0] data;
  logic        mode;
  logic [7:0]  dots_in;
  logic        busy;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;

  logic        load2;
  logic [15:0] data2;
  logic        mode2;
  logic [3:0]  dots2;
  logic        busy2;
  logic [6:0]  seg2;
  logic        dp2;
  logic [3:0]  an2;

  exp_t        sbq[$];
  int          n_pass;
  int          n_total;

  logic [6:0]  glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  seg_scan_ctrl #(
    .DIGITS   (8),
    .DATA_W   (24),
    .DIV      (4),
    .BLANK_LZ (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .data    (data),
    .mode    (mode),
    .dots_in (dots_in),
    .busy    (busy),
    .seg     (seg),
    .dp      (dp),
    .an      (an)
  );

  seg_scan_ctrl #(
    .DIGITS   (4),
    .DATA_W   (16),
    .DIV      (4),
    .BLANK_LZ (1)
  ) dut4 (
    .clk     (clk),
    .rst     (rst),
    .load    (load2),
    .data    (data2),
    .mode    (mode2),
    .dots_in (dots2),
    .busy    (busy2),
    .seg     (seg2),
    .dp      (dp2),
    .an      (an2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_digit(input int i, input logic [6:0] s,
                            input logic d);
    exp_t e;
    e.an  = ~(8'd1 << i);
    e.seg = s;
    e.dp  = d;
    sbq.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (seg !== 7'h7F) $display("FAIL rst_seg got %h want 7f", seg);
    else n_pass++;
    n_total++;
    if (an !== 8'hFF) $display("FAIL rst_an got %h want ff", an);
    else n_pass++;
    n_total++;
    if (dp !== 1'b1) $display("FAIL rst_dp got %b want 1", dp);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy);
    else n_pass++;
    n_total++;
    if (an2 !== 4'hF) $display("FAIL rst_an4 got %h want f", an2);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (an !== 8'hFE) $display("FAIL rel_an got %h want fe", an);
    else n_pass++;
    n_total++;
    if (seg !== 7'h40) $display("FAIL rel_seg got %h want 40", seg);
    else n_pass++;
  endtask

  task automatic test_hex();
    exp_t e;
    int   n;
    logic bz;
    logic [6:0] s;
    logic [23:0] v;
    v = 24'hABC123;
    data = v; mode = 1'b0; dots_in = 8'h04; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    bz = (busy !== 1'b0);
    for (int i = 0; i < 8; i++) begin
      s = (i < 6) ? glyph[v[4*i +: 4]] : 7'h7F;
      push_digit(i, s, (i == 2) ? 1'b0 : 1'b1);
    end
    repeat (2) @(negedge clk);
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      n = 0;
      while (an !== e.an && n < 80) begin
        @(negedge clk);
        n++;
        if (busy !== 1'b0) bz = 1'b1;
      end
      n_total++;
      if (an !== e.an) $display("FAIL hex_an got %h want %h", an, e.an);
      else n_pass++;
      n_total++;
      if (seg !== e.seg)
        $display("FAIL hex_seg an=%h got %h want %h", an, seg, e.seg);
      else n_pass++;
      n_total++;
      if (dp !== e.dp)
        $display("FAIL hex_dp an=%h got %b want %b", an, dp, e.dp);
      else n_pass++;
    end
    n_total++;
    if (bz !== 1'b0) $display("FAIL hex_busy got 1 want 0");
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   n;
    data = 24'h123456; mode = 1'b0; dots_in = 8'hFF; load = 1'b1;
    @(negedge clk);
    data = 24'h000F00; dots_in = 8'h80;
    @(negedge clk);
    load = 1'b0;
    push_digit(0, 7'h40, 1'b1);
    push_digit(1, 7'h40, 1'b1);
    push_digit(2, 7'h0E, 1'b1);
    for (int i = 3; i < 7; i++) push_digit(i, 7'h7F, 1'b1);
    push_digit(7, 7'h7F, 1'b0);
    repeat (2) @(negedge clk);
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      n = 0;
      while (an !== e.an && n < 80) begin
        @(negedge clk);
        n++;
      end
      n_total++;
      if (an !== e.an) $display("FAIL b2b_an got %h want %h", an, e.an);
      else n_pass++;
      n_total++;
      if (seg !== e.seg)
        $display("FAIL b2b_seg an=%h got %h want %h", an, seg, e.seg);
      else n_pass++;
      n_total++;
      if (dp !== e.dp)
        $display("FAIL b2b_dp an=%h got %b want %b", an, dp, e.dp);
      else n_pass++;
    end
  endtask

  task automatic test_decimal(input logic ignored_load);
    exp_t e;
    int   n;
    int   v;
    int   dg;
    v = 1234567;
    data = 24'(v); mode = 1'b1;
    dots_in = ignored_load ? 8'h00 : 8'h10;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dg = (v / (10 ** i)) % 10;
      push_digit(i, (i < 7) ? glyph[dg] : 7'h7F,
                 (!ignored_load && i == 4) ? 1'b0 : 1'b1);
    end
    n_total++;
    if (busy !== 1'b1) $display("FAIL dec_busy_rise got %b want 1", busy);
    else n_pass++;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (ignored_load && n == 3) begin
        load = 1'b1; data = 24'd5; dots_in = 8'h01;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    load = 1'b0;
    n_total++;
    if (n != 24) $display("FAIL dec_busy_len got %0d want 24", n);
    else n_pass++;
    repeat (2) @(negedge clk);
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      n = 0;
      while (an !== e.an && n < 80) begin
        @(negedge clk);
        n++;
      end
      n_total++;
      if (an !== e.an) $display("FAIL dec_an got %h want %h", an, e.an);
      else n_pass++;
      n_total++;
      if (seg !== e.seg)
        $display("FAIL dec_seg an=%h got %h want %h", an, seg, e.seg);
      else n_pass++;
      n_total++;
      if (dp !== e.dp)
        $display("FAIL dec_dp an=%h got %b want %b", an, dp, e.dp);
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    int   n;
    int   vals [3] = '{9999, 10000, 12345};
    logic [6:0] s;
    for (int k = 0; k < 3; k++) begin
      data2 = 16'(vals[k]); mode2 = 1'b1;
      dots2 = (k == 2) ? 4'h1 : 4'h0;
      load2 = 1'b1;
      @(negedge clk);
      load2 = 1'b0;
      s = (vals[k] > 9999) ? 7'h3F : 7'h10;
      for (int i = 0; i < 4; i++)
        push_digit(i, s, (k == 2 && i == 0) ? 1'b0 : 1'b1);
      n = 0;
      while (busy2 === 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      n_total++;
      if (n != 16) $display("FAIL ovf_busy_len got %0d want 16", n);
      else n_pass++;
      repeat (2) @(negedge clk);
      while (sbq.size() != 0) begin
        e = sbq.pop_front();
        n = 0;
        while ({4'hF, an2} !== e.an && n < 40) begin
          @(negedge clk);
          n++;
        end
        n_total++;
        if ({4'hF, an2} !== e.an)
          $display("FAIL ovf_an got %h want %h", an2, e.an[3:0]);
        else n_pass++;
        n_total++;
        if (seg2 !== e.seg)
          $display("FAIL ovf_seg v=%0d an=%h got %h want %h",
                   vals[k], an2, seg2, e.seg);
        else n_pass++;
        n_total++;
        if (dp2 !== e.dp)
          $display("FAIL ovf_dp an=%h got %b want %b", an2, dp2, e.dp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   n;
    logic bz;
    data = 24'd42; mode = 1'b1; dots_in = 8'h00; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 9) begin
      @(negedge clk);
      n++;
    end
    n_total++;
    if (busy !== 1'b1) $display("FAIL mid_busy10 got %b want 1", busy);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0) $display("FAIL mid_busy got %b want 0", busy);
    else n_pass++;
    n_total++;
    if (an !== 8'hFF) $display("FAIL mid_an got %h want ff", an);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (an !== 8'hFE || seg !== 7'h40)
      $display("FAIL mid_rel an=%h seg=%h want fe 40", an, seg);
    else n_pass++;
    push_digit(0, 7'h40, 1'b1);
    for (int i = 1; i < 8; i++) push_digit(i, 7'h7F, 1'b1);
    bz = 1'b0;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      n = 0;
      while (an !== e.an && n < 80) begin
        @(negedge clk);
        n++;
        if (busy !== 1'b0) bz = 1'b1;
      end
      n_total++;
      if (an !== e.an) $display("FAIL mid_an2 got %h want %h", an, e.an);
      else n_pass++;
      n_total++;
      if (seg !== e.seg)
        $display("FAIL mid_seg an=%h got %h want %h", an, seg, e.seg);
      else n_pass++;
      n_total++;
      if (dp !== e.dp)
        $display("FAIL mid_dp an=%h got %b want %b", an, dp, e.dp);
      else n_pass++;
    end
    n_total++;
    if (bz !== 1'b0) $display("FAIL mid_stale_busy got 1 want 0");
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    load    = 1'b0;
    data    = '0;
    mode    = 1'b0;
    dots_in = '0;
    load2   = 1'b0;
    data2   = '0;
    mode2   = 1'b0;
    dots2   = '0;
    test_reset();
    test_hex();
    test_back_to_back();
    test_decimal(1'b0);
    test_decimal(1'b1);
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
